// File: rtl/rr_logging_packer_pkg.sv
// -----------------------------------------------------------------------------
// rr_logging_packer_pkg
// Shared definitions for the round-robin logging packer: header field offsets,
// the default channel width and the output FSM state encoding.
// -----------------------------------------------------------------------------
package rr_logging_packer_pkg;

  // Default width of one logging channel.
  localparam int RR_CHANNEL_WIDTH_BITS = 128;

  // Header beat layout: sequence number field position and width.
  localparam int SEQ_LSB = 32;
  localparam int SEQ_W   = 16;

  // Output framing FSM.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_e;

endpackage

// File: rtl/rr_logging_packer_fifo.sv
// -----------------------------------------------------------------------------
// rr_pack_fifo
// Synchronous single-clock FIFO holding captured log records.
// A push while full is ignored unless a pop happens in the same cycle.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push_i      write din_i this cycle
//   din_i       record to write
//   pop_i       retire the head entry this cycle
//   dout_o      head entry (valid while !empty_o)
//   count_o     current occupancy, 0..DEPTH
//   full_o      occupancy == DEPTH
//   empty_o     occupancy == 0
// -----------------------------------------------------------------------------
module rr_pack_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          wr_en;
  logic          rd_en;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign wr_en = push_i && (!full_o || pop_i);
  assign rd_en = pop_i && !empty_o;

  // NOTE: the storage array has no reset; the count and pointers alone decide
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rr_logging_packer.sv
// -----------------------------------------------------------------------------
// rr_logging_packer
// Captures per-channel begin/end log events into a record FIFO and streams each
// record as one header beat followed by the valid channels packed densely into
// OUT_W-wide data beats.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   logb_valid      per-channel begin-log valid (NCH)
//   loge_valid      per-channel end-log valid (NCH)
//   logb_data       channel i payload at [i*CH_W +: CH_W]
//   logb_almful_hi  registered, occupancy >= DEPTH-2
//   logb_almful_lo  registered, occupancy >= DEPTH/2
//   out_valid/out_ready/out_data/out_last  beat stream, last marks record end
//   overflow_err    sticky: a record was dropped on a full buffer
// -----------------------------------------------------------------------------
module rr_logging_packer
  import rr_logging_packer_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int CH_W  = RR_CHANNEL_WIDTH_BITS,
  parameter int OUT_W = 512,
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      logb_valid,
  input  logic [NCH-1:0]      loge_valid,
  input  logic [NCH*CH_W-1:0] logb_data,
  output logic                logb_almful_hi,
  output logic                logb_almful_lo,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_last,
  output logic                overflow_err
);

  localparam int SLOTS     = OUT_W / CH_W;
  localparam int MAX_BEATS = (NCH + SLOTS - 1) / SLOTS;
  localparam int BW        = $clog2(MAX_BEATS + 1);
  localparam int CW        = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] HI_TH = CW'(DEPTH - 2);
  localparam logic [CW-1:0] LO_TH = CW'(DEPTH / 2);

  if (OUT_W % CH_W != 0) begin : g_bad_out_w
    $error("OUT_W must be a multiple of CH_W");
  end
  if (2 * NCH > 32) begin : g_bad_nch
    $error("2*NCH must not exceed 32 header bits");
  end
  if (OUT_W < SEQ_LSB + SEQ_W) begin : g_bad_hdr
    $error("OUT_W too narrow for the header sequence field");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two, at least 4");
  end

  typedef struct packed {
    logic [NCH-1:0]      logb;
    logic [NCH-1:0]      loge;
    logic [NCH*CH_W-1:0] data;
  } rec_t;

  rec_t                     wr_rec;
  rec_t                     head;
  logic [CW-1:0]            fifo_count;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     capture;
  logic                     push;
  logic                     pop;
  logic                     hs;
  logic                     more;
  logic [CW-1:0]            count_d;

  state_e                   state_q;
  logic [BW-1:0]            beat_q;
  logic [SEQ_W-1:0]         seq_q;
  logic                     almful_hi_q;
  logic                     almful_lo_q;
  logic                     overflow_q;

  int                       n_chans;
  logic [BW-1:0]            n_beats;
  logic [MAX_BEATS*OUT_W-1:0] compact;
  logic [OUT_W-1:0]         hdr;

  assign wr_rec  = '{logb: logb_valid, loge: loge_valid, data: logb_data};
  assign capture = (|logb_valid) || (|loge_valid);
  // A full buffer still accepts a record when the head retires in the same cycle.
  assign push    = capture && (!fifo_full || pop);
  assign hs      = out_valid && out_ready;
  assign pop     = hs && out_last;
  // Another record is ready to follow the one being retired.
  assign more    = (fifo_count > CW'(1)) || push;

  rr_pack_fifo #(
    .W     ($bits(rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (wr_rec),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Compact the valid channels of the head record in ascending index order.
  // NOTE: every variable written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    compact = '0;
    n_chans = 0;
    for (int i = 0; i < NCH; i++) begin
      if (head.logb[i]) begin
        compact[n_chans*CH_W +: CH_W] = head.data[i*CH_W +: CH_W];
        n_chans++;
      end
    end
    n_beats = BW'((n_chans + SLOTS - 1) / SLOTS);
  end

  always_comb begin
    hdr                    = '0;
    hdr[NCH-1:0]           = head.logb;
    hdr[NCH +: NCH]        = head.loge;
    hdr[SEQ_LSB +: SEQ_W]  = seq_q;
  end

  // Beat outputs are decoded from registered state and the FIFO head, so a
  // record captured in one cycle can present its header in the next.
  assign out_valid = (state_q != IDLE);

  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    unique case (state_q)
      HDR: begin
        out_data = hdr;
        out_last = (n_beats == '0);
      end
      DATA: begin
        out_data = compact[int'(beat_q)*OUT_W +: OUT_W];
        out_last = (beat_q == n_beats - BW'(1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      seq_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty || push) state_q <= HDR;
        end
        HDR: begin
          if (hs) begin
            if (n_beats != '0) begin
              state_q <= DATA;
              beat_q  <= '0;
            end else begin
              seq_q   <= seq_q + SEQ_W'(1);
              state_q <= more ? HDR : IDLE;
            end
          end
        end
        DATA: begin
          if (hs) begin
            if (out_last) begin
              seq_q   <= seq_q + SEQ_W'(1);
              beat_q  <= '0;
              state_q <= more ? HDR : IDLE;
            end else begin
              beat_q  <= beat_q + BW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Occupancy after this edge; the flags track it with no extra lag.
  always_comb begin
    count_d = fifo_count;
    if (push && !pop)      count_d = fifo_count + CW'(1);
    else if (!push && pop) count_d = fifo_count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almful_hi_q <= 1'b0;
      almful_lo_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      almful_hi_q <= (count_d >= HI_TH);
      almful_lo_q <= (count_d >= LO_TH);
      if (capture && !push) overflow_q <= 1'b1;
    end
  end

  assign logb_almful_hi = almful_hi_q;
  assign logb_almful_lo = almful_lo_q;
  assign overflow_err   = overflow_q;

endmodule

// File: tb/tb_rr_logging_packer.sv
module tb_rr_logging_packer;

  localparam int NCH   = 8;
  localparam int CH_W  = 128;
  localparam int OUT_W = 512;
  localparam int DEPTH = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NCH-1:0]      logb_valid;
  logic [NCH-1:0]      loge_valid;
  logic [NCH*CH_W-1:0] logb_data;
  logic                logb_almful_hi;
  logic                logb_almful_lo;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    out_data;
  logic                out_last;
  logic                overflow_err;

  always #5 clk = ~clk;

  rr_logging_packer #(
    .NCH   (NCH),
    .CH_W  (CH_W),
    .OUT_W (OUT_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .logb_valid     (logb_valid),
    .loge_valid     (loge_valid),
    .logb_data      (logb_data),
    .logb_almful_hi (logb_almful_hi),
    .logb_almful_lo (logb_almful_lo),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .overflow_err   (overflow_err)
  );

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             last;
  } beat_t;

  beat_t            sb[$];
  int               cmp_cnt = 0;
  int               fail_cnt = 0;
  logic [15:0]      exp_seq;
  logic             stall_q = 1'b0;
  logic [OUT_W-1:0] stall_data;
  logic             stall_last;

  task automatic check(input string name, input logic [OUT_W-1:0] act,
                       input logic [OUT_W-1:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [CH_W-1:0] pat(input int i);
    return {4{32'hA5C3_0000 + 32'(i)}};
  endfunction

  // Header: [7:0]=logb, [15:8]=loge, [47:32]=sequence, everything else zero.
  function automatic logic [OUT_W-1:0] hdr(input logic [7:0] b, input logic [7:0] e,
                                           input logic [15:0] s);
    return {{(OUT_W-48){1'b0}}, s, 16'h0000, e, b};
  endfunction

  task automatic expect_beat(input logic [OUT_W-1:0] d, input logic l);
    beat_t bt;
    bt.data = d;
    bt.last = l;
    sb.push_back(bt);
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] e,
                      input logic [NCH*CH_W-1:0] d);
    @(posedge clk); #1;
    logb_valid = b;
    loge_valid = e;
    logb_data  = d;
    @(posedge clk); #1;
    logb_valid = '0;
    loge_valid = '0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    check(name, OUT_W'(sb.size()), '0);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks that a stalled
  // beat holds still until it is taken.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (stall_q) begin
        check("stall_valid", OUT_W'(out_valid), OUT_W'(1));
        check("stall_data", out_data, stall_data);
        check("stall_last", OUT_W'(out_last), OUT_W'(stall_last));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          cmp_cnt++;
          fail_cnt++;
          $display("FAIL unexpected_beat: got %0h want no beat", out_data);
        end else begin
          e = sb.pop_front();
          check("beat_data", out_data, e.data);
          check("beat_last", OUT_W'(out_last), OUT_W'(e.last));
        end
      end
      stall_q    = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
    end else begin
      stall_q = 1'b0;
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NCH*CH_W-1:0] d;
    int bubbles;

    rst_n      = 1'b0;
    out_ready  = 1'b1;
    logb_valid = '0;
    loge_valid = '0;
    logb_data  = '0;
    exp_seq    = '0;
    for (int i = 0; i < NCH; i++) d[i*CH_W +: CH_W] = pat(i);

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", OUT_W'(out_valid), '0);
    check("rst_out_last", OUT_W'(out_last), '0);
    check("rst_out_data", out_data, '0);
    check("rst_almful_hi", OUT_W'(logb_almful_hi), '0);
    check("rst_almful_lo", OUT_W'(logb_almful_lo), '0);
    check("rst_overflow", OUT_W'(overflow_err), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Channels 0 and 2 valid: one data beat {0, 0, ch2, ch0}.
    expect_beat(hdr(8'h05, 8'h00, 16'h0000), 1'b0);
    expect_beat({256'h0, pat(2), pat(0)}, 1'b1);
    send(8'h05, 8'h00, d);
    @(negedge clk);
    check("latency_hdr_valid", OUT_W'(out_valid), OUT_W'(1));
    drain("drain_two_ch");

    // End-log only: header is also the last beat.
    expect_beat(hdr(8'h00, 8'h80, 16'h0001), 1'b1);
    send(8'h00, 8'h80, d);
    drain("drain_hdr_only");

    // All eight channels: two data beats, consumer toggling ready.
    expect_beat(hdr(8'hFF, 8'h00, 16'h0002), 1'b0);
    expect_beat({pat(3), pat(2), pat(1), pat(0)}, 1'b0);
    expect_beat({pat(7), pat(6), pat(5), pat(4)}, 1'b1);
    send(8'hFF, 8'h00, d);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    drain("drain_toggle");

    // Fill the buffer with ready low: nine records, the ninth is dropped.
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    exp_seq   = '0;
    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) expect_beat(hdr(8'h00, 8'(k), 16'(k - 1)), 1'b1);
    @(posedge clk); #1;
    loge_valid = 8'h01;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      check($sformatf("almful_hi_%0d", k), OUT_W'(logb_almful_hi), OUT_W'(k >= 6));
      check($sformatf("almful_lo_%0d", k), OUT_W'(logb_almful_lo), OUT_W'(k >= 4));
      check($sformatf("overflow_%0d", k), OUT_W'(overflow_err), OUT_W'(k >= 9));
      loge_valid = (k < 9) ? 8'(k + 1) : 8'h00;
    end
    out_ready = 1'b1;
    drain("drain_full");
    check("overflow_sticky", OUT_W'(overflow_err), OUT_W'(1));
    check("almful_lo_empty", OUT_W'(logb_almful_lo), '0);
    exp_seq = 16'd8;

    // Back-to-back header-only records across the sequence wrap.
    bubbles = 0;
    for (int k = 0; k < 70000; k++) begin
      @(posedge clk); #1;
      if (k >= 1 && out_valid !== 1'b1) bubbles++;
      logb_valid = '0;
      loge_valid = 8'h40;
      expect_beat(hdr(8'h00, 8'h40, exp_seq), 1'b1);
      exp_seq++;
    end
    @(posedge clk); #1;
    if (out_valid !== 1'b1) bubbles++;
    loge_valid = '0;
    drain("drain_stream");
    check("stream_no_bubble", OUT_W'(bubbles), '0);

    // Reset while a data beat is stalled: the record is abandoned.
    expect_beat(hdr(8'hFF, 8'h00, exp_seq), 1'b0);
    send(8'hFF, 8'h00, d);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", OUT_W'(out_valid), '0);
    check("midrst_out_data", out_data, '0);
    check("midrst_out_last", OUT_W'(out_last), '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_idle_%0d", i), OUT_W'(out_valid), '0);
    end
    check("post_rst_queue", OUT_W'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
